// File: rtl/mem_pkg.sv
// ============================================================================
// Module      : mem_pkg
// Description : Shared types and constants for the memory-access stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT_R = 2'd1,
        WAIT_W = 2'd2
    } state_t;

    localparam int c_ADDR_W = 32;
    localparam int c_DATA_W = 32;
    localparam int c_STRB_W = 4;
    localparam int c_RD_W   = 5;
    localparam int c_CNT_W  = 8;

    localparam logic [2:0] c_WIDTH_BYTE = 3'd1;
    localparam logic [2:0] c_WIDTH_HALF = 3'd2;
    localparam logic [2:0] c_WIDTH_WORD = 3'd4;

    function automatic logic [2:0] strb_count(input logic [c_STRB_W-1:0] strb);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < c_STRB_W; i++) begin
            n = n + {2'b00, strb[i]};
        end
        return n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/load_align.sv
// ============================================================================
// Module      : load_align
// Description : Aligns and sign/zero-extends load data selected by a strobe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_align
    import mem_pkg::*;
(
    input  logic [c_STRB_W-1:0] i_strb,
    input  logic                i_signed,
    input  logic [c_DATA_W-1:0] i_rdata,
    output logic [c_DATA_W-1:0] o_result
);

    logic [1:0]          w_off;
    logic [c_DATA_W-1:0] w_shift;

    always_comb begin
        // Lowest set strobe bit marks the byte lane holding the LSB of the load.
        w_off = 2'd0;
        for (int i = c_STRB_W - 1; i >= 0; i--) begin
            if (i_strb[i]) w_off = 2'(i);
        end
        w_shift  = i_rdata >> {w_off, 3'b000};
        o_result = w_shift;
        case (strb_count(i_strb))
            c_WIDTH_BYTE: o_result = {{24{i_signed & w_shift[7]}}, w_shift[7:0]};
            c_WIDTH_HALF: o_result = {{16{i_signed & w_shift[15]}}, w_shift[15:0]};
            c_WIDTH_WORD: o_result = w_shift;
            default:      o_result = w_shift;
        endcase
        if (i_strb == '0) o_result = '0;
    end

endmodule

`default_nettype wire

// File: rtl/mem_access.sv
// ============================================================================
// Module      : mem_access
// Description : Issues loads/stores to the data bus, stalls until ACK or
//               timeout, and registers the writeback/forwarding value.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [c_RD_W-1:0]   REG_W_RD,
    input  logic [c_DATA_W-1:0] REG_W_DATA,
    input  logic                MEM_R_VALID,
    input  logic [c_RD_W-1:0]   MEM_R_RD,
    input  logic [c_ADDR_W-1:0] MEM_R_ADDR,
    input  logic [c_STRB_W-1:0] MEM_R_STRB,
    input  logic                MEM_R_SIGNED,
    input  logic                MEM_W_VALID,
    input  logic [c_ADDR_W-1:0] MEM_W_ADDR,
    input  logic [c_STRB_W-1:0] MEM_W_STRB,
    input  logic [c_DATA_W-1:0] MEM_W_DATA,
    output logic                STALL,
    output logic                DMEM_REQ,
    output logic                DMEM_WE,
    output logic [c_ADDR_W-1:0] DMEM_ADDR,
    output logic [c_STRB_W-1:0] DMEM_STRB,
    output logic [c_DATA_W-1:0] DMEM_WDATA,
    input  logic                DMEM_ACK,
    input  logic [c_DATA_W-1:0] DMEM_RDATA,
    output logic [c_RD_W-1:0]   WB_RD,
    output logic [c_DATA_W-1:0] WB_DATA,
    output logic                BUS_ERR
);

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT - 1);

    state_t              r_state;
    state_t              w_next;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_req;
    logic                r_we;
    logic [c_ADDR_W-1:0] r_addr;
    logic [c_STRB_W-1:0] r_strb;
    logic [c_DATA_W-1:0] r_wdata;
    logic [c_RD_W-1:0]   r_rd;
    logic                r_signed;
    logic [c_RD_W-1:0]   r_wb_rd;
    logic [c_DATA_W-1:0] r_wb_data;
    logic                r_bus_err;
    logic                w_timeout;
    logic                w_done;
    logic [c_DATA_W-1:0] w_rdata;
    logic [c_DATA_W-1:0] w_load_data;

    // A simultaneous ACK wins over the timeout, so the error is suppressed.
    assign w_timeout = (r_state != IDLE) && !DMEM_ACK && (r_cnt == c_CNT_LAST);
    assign w_done    = (r_state != IDLE) && (DMEM_ACK || w_timeout);
    assign w_rdata   = DMEM_ACK ? DMEM_RDATA : '0;

    load_align u_load_align (
        .i_strb   (r_strb),
        .i_signed (r_signed),
        .i_rdata  (w_rdata),
        .o_result (w_load_data)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) r_state <= IDLE;
        else      r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        STALL  = 1'b0;
        case (r_state)
            IDLE: begin
                STALL = MEM_R_VALID | MEM_W_VALID;
                if (MEM_R_VALID)      w_next = WAIT_R;
                else if (MEM_W_VALID) w_next = WAIT_W;
            end
            WAIT_R, WAIT_W: begin
                STALL = !w_done;
                if (w_done) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_strb    <= '0;
            r_wdata   <= '0;
            r_rd      <= '0;
            r_signed  <= 1'b0;
            r_wb_rd   <= '0;
            r_wb_data <= '0;
            r_bus_err <= 1'b0;
        end else begin
            r_bus_err <= 1'b0;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (MEM_R_VALID) begin
                    r_req    <= 1'b1;
                    r_we     <= 1'b0;
                    r_addr   <= MEM_R_ADDR;
                    r_strb   <= MEM_R_STRB;
                    r_wdata  <= '0;
                    r_rd     <= MEM_R_RD;
                    r_signed <= MEM_R_SIGNED;
                    r_wb_rd  <= '0;
                end else if (MEM_W_VALID) begin
                    r_req   <= 1'b1;
                    r_we    <= 1'b1;
                    r_addr  <= MEM_W_ADDR;
                    r_strb  <= MEM_W_STRB;
                    r_wdata <= MEM_W_DATA;
                    r_wb_rd <= '0;
                end else begin
                    r_wb_rd   <= REG_W_RD;
                    r_wb_data <= REG_W_DATA;
                end
            end else if (w_done) begin
                r_req     <= 1'b0;
                r_cnt     <= '0;
                r_bus_err <= w_timeout;
                if (r_state == WAIT_R) begin
                    r_wb_rd   <= r_rd;
                    r_wb_data <= w_load_data;
                end else begin
                    r_wb_rd <= '0;
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign DMEM_REQ   = r_req;
    assign DMEM_WE    = r_we;
    assign DMEM_ADDR  = r_addr;
    assign DMEM_STRB  = r_strb;
    assign DMEM_WDATA = r_wdata;
    assign WB_RD      = r_wb_rd;
    assign WB_DATA    = r_wb_data;
    assign BUS_ERR    = r_bus_err;

endmodule

`default_nettype wire

// File: tb/tb_mem_access.sv
// ============================================================================
// Module      : tb_mem_access
// Description : Self-checking bench for mem_access (TIMEOUT = 4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access;

    localparam int c_TO = 4;

    logic        CLK, RST;
    logic [4:0]  REG_W_RD;
    logic [31:0] REG_W_DATA;
    logic        MEM_R_VALID, MEM_R_SIGNED, MEM_W_VALID;
    logic [4:0]  MEM_R_RD;
    logic [31:0] MEM_R_ADDR, MEM_W_ADDR, MEM_W_DATA;
    logic [3:0]  MEM_R_STRB, MEM_W_STRB;
    logic        STALL, DMEM_REQ, DMEM_WE, DMEM_ACK, BUS_ERR;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA, WB_DATA;
    logic [3:0]  DMEM_STRB;
    logic [4:0]  WB_RD;

    mem_access #(.TIMEOUT(c_TO)) dut (
        .CLK(CLK), .RST(RST),
        .REG_W_RD(REG_W_RD), .REG_W_DATA(REG_W_DATA),
        .MEM_R_VALID(MEM_R_VALID), .MEM_R_RD(MEM_R_RD), .MEM_R_ADDR(MEM_R_ADDR),
        .MEM_R_STRB(MEM_R_STRB), .MEM_R_SIGNED(MEM_R_SIGNED),
        .MEM_W_VALID(MEM_W_VALID), .MEM_W_ADDR(MEM_W_ADDR), .MEM_W_STRB(MEM_W_STRB),
        .MEM_W_DATA(MEM_W_DATA),
        .STALL(STALL), .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_STRB(DMEM_STRB), .DMEM_WDATA(DMEM_WDATA), .DMEM_ACK(DMEM_ACK),
        .DMEM_RDATA(DMEM_RDATA), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .BUS_ERR(BUS_ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        we;
        logic [3:0]  strb;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          n_ack;     // 0 = never acknowledge
        logic [31:0] exp_data;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    int   errors = 0;
    int   checks = 0;
    exp_t sb_q[$];
    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Entered and left at #1 after a rising edge; the next op may start immediately.
    task automatic mem_op(input vec_t v);
        int   stalls;
        int   done_cyc;
        int   exp_done;
        logic cmd_ok;
        exp_t e;
        MEM_R_VALID  = !v.we;
        MEM_W_VALID  = v.we;
        MEM_R_ADDR   = v.addr;
        MEM_W_ADDR   = v.addr;
        MEM_R_STRB   = v.strb;
        MEM_W_STRB   = v.strb;
        MEM_R_SIGNED = v.sgn;
        MEM_R_RD     = v.rd;
        MEM_W_DATA   = v.wdata;
        sb_q.push_back('{we: v.we, rd: (v.we ? 5'd0 : v.rd), data: v.exp_data, err: v.exp_err});
        exp_done = (v.n_ack >= 1 && v.n_ack <= c_TO) ? v.n_ack : c_TO;
        stalls   = 0;
        done_cyc = 0;
        cmd_ok   = 1'b1;
        @(negedge CLK);
        if (STALL) stalls++;
        if (DMEM_REQ) cmd_ok = 1'b0;
        @(posedge CLK); #1;
        MEM_R_VALID = 1'b0;
        MEM_W_VALID = 1'b0;
        for (int i = 1; i <= 16 && done_cyc == 0; i++) begin
            DMEM_ACK   = (i == v.n_ack);
            DMEM_RDATA = v.rdata;
            @(negedge CLK);
            if (!DMEM_REQ || DMEM_WE !== v.we || DMEM_ADDR !== v.addr || DMEM_STRB !== v.strb ||
                (v.we && DMEM_WDATA !== v.wdata)) cmd_ok = 1'b0;
            if (STALL) stalls++;
            else done_cyc = i;
            @(posedge CLK); #1;
        end
        DMEM_ACK   = 1'b0;
        DMEM_RDATA = 32'h0;
        check("stall_cycles", 32'(stalls), 32'(exp_done));
        check("cmd_stable", {31'b0, cmd_ok}, 32'd1);
        check("req_dropped", {31'b0, DMEM_REQ}, 32'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = sb_q.pop_front();
            check("wb_rd", {27'b0, WB_RD}, {27'b0, e.rd});
            if (!e.we) check("wb_data", WB_DATA, e.data);
            check("bus_err", {31'b0, BUS_ERR}, {31'b0, e.err});
        end
    endtask

    initial begin
        RST = 1'b0;
        REG_W_RD = '0; REG_W_DATA = '0;
        MEM_R_VALID = 0; MEM_R_RD = '0; MEM_R_ADDR = '0; MEM_R_STRB = '0; MEM_R_SIGNED = 0;
        MEM_W_VALID = 0; MEM_W_ADDR = '0; MEM_W_STRB = '0; MEM_W_DATA = '0;
        DMEM_ACK = 0; DMEM_RDATA = '0;

        //           we  strb     sgn addr          wdata         rdata         rd  n  exp           err
        vecs[0] = '{1'b1, 4'b1111, 0, 32'h100, 32'hDEADBEEF, 32'h0,        5'd0,  1, 32'h0,        0};
        vecs[1] = '{1'b0, 4'b1111, 0, 32'h100, 32'h0,        32'hDEADBEEF, 5'd3,  1, 32'hDEADBEEF, 0};
        vecs[2] = '{1'b0, 4'b0100, 1, 32'h202, 32'h0,        32'h00F00000, 5'd4,  3, 32'hFFFFFFF0, 0};
        vecs[3] = '{1'b0, 4'b1100, 0, 32'h302, 32'h0,        32'h80010000, 5'd6,  1, 32'h00008001, 0};
        vecs[4] = '{1'b0, 4'b1100, 1, 32'h302, 32'h0,        32'h80010000, 5'd7,  2, 32'hFFFF8001, 0};
        vecs[5] = '{1'b0, 4'b0001, 0, 32'h400, 32'h0,        32'h123456A5, 5'd0,  1, 32'h000000A5, 0};
        vecs[6] = '{1'b0, 4'b0011, 1, 32'h500, 32'h0,        32'h00007FFF, 5'd8,  2, 32'h00007FFF, 0};
        vecs[7] = '{1'b0, 4'b1111, 0, 32'h600, 32'h0,        32'hAAAA5555, 5'd9,  0, 32'h0,        1};
        vecs[8] = '{1'b0, 4'b1000, 1, 32'h703, 32'h0,        32'h80000000, 5'd10, 4, 32'hFFFFFF80, 0};
        vecs[9] = '{1'b0, 4'b0000, 1, 32'h800, 32'h0,        32'hFFFFFFFF, 5'd11, 1, 32'h0,        0};

        repeat (2) @(posedge CLK);
        #1;
        check("rst_req", {31'b0, DMEM_REQ}, 32'd0);
        check("rst_stall", {31'b0, STALL}, 32'd0);
        check("rst_wb_rd", {27'b0, WB_RD}, 32'd0);
        check("rst_wb_data", WB_DATA, 32'd0);
        check("rst_bus_err", {31'b0, BUS_ERR}, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;

        // ALU-only traffic: registered one cycle later, never stalls.
        for (int k = 0; k < 3; k++) begin
            REG_W_RD   = (k == 0) ? 5'd5 : (k == 1) ? 5'd31 : 5'd0;
            REG_W_DATA = (k == 0) ? 32'h1234 : (k == 1) ? 32'hFFFFFFFF : 32'hCAFE;
            @(negedge CLK);
            check("alu_stall", {31'b0, STALL}, 32'd0);
            @(posedge CLK); #1;
            check("alu_wb_rd", {27'b0, WB_RD}, {27'b0, REG_W_RD});
            check("alu_wb_data", WB_DATA, REG_W_DATA);
        end
        REG_W_RD = '0; REG_W_DATA = '0;

        // Memory ops issued back-to-back.
        for (int k = 0; k < 10; k++) begin
            mem_op(vecs[k]);
            if (vecs[k].exp_err) begin
                @(posedge CLK); #1;
                check("bus_err_single_pulse", {31'b0, BUS_ERR}, 32'd0);
            end
        end

        // Reset during WAIT_R, then a stale ACK after release.
        REG_W_RD = 5'd7; REG_W_DATA = 32'h77;
        MEM_R_VALID = 1; MEM_R_RD = 5'd12; MEM_R_ADDR = 32'h900; MEM_R_STRB = 4'b1111; MEM_R_SIGNED = 0;
        @(posedge CLK); #1;
        MEM_R_VALID = 0;
        @(posedge CLK); #1;
        check("wait_r_req", {31'b0, DMEM_REQ}, 32'd1);
        RST = 1'b0;
        #1;
        check("midrst_req", {31'b0, DMEM_REQ}, 32'd0);
        check("midrst_stall", {31'b0, STALL}, 32'd0);
        check("midrst_wb_rd", {27'b0, WB_RD}, 32'd0);
        check("midrst_wb_data", WB_DATA, 32'd0);
        @(negedge CLK);
        RST = 1'b1;
        @(posedge CLK); #1;
        DMEM_ACK = 1; DMEM_RDATA = 32'h12345678;
        @(negedge CLK);
        check("late_ack_stall", {31'b0, STALL}, 32'd0);
        @(posedge CLK); #1;
        DMEM_ACK = 0; DMEM_RDATA = '0;
        check("late_ack_wb_rd", {27'b0, WB_RD}, 32'd7);
        check("late_ack_wb_data", WB_DATA, 32'h77);
        check("late_ack_req", {31'b0, DMEM_REQ}, 32'd0);
        check("late_ack_bus_err", {31'b0, BUS_ERR}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
